// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg
// Types and constants shared by the CPU control unit and the exception
// sequencer: ALU operation codes, the exception FSM state encoding, cause
// codes and the default datapath mux select values used during an exception.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        ALU_LOAD = 3'd0,
        ALU_ADD  = 3'd1,
        ALU_SUB  = 3'd2,
        ALU_AND  = 3'd3,
        ALU_INC  = 3'd4,
        ALU_NEG  = 3'd5,
        ALU_XOR  = 3'd6,
        ALU_COMP = 3'd7
    } alu_op_t;

    // The encoding is visible on state_out and is relied on by debug tools.
    typedef enum logic [2:0] {
        EXC_IDLE  = 3'd0,
        EXC_SAVE  = 3'd1,
        EXC_FETCH = 3'd2,
        EXC_LOAD  = 3'd3,
        EXC_DONE  = 3'd4
    } exc_state_t;

    localparam logic CAUSE_OPCODE = 1'b0;
    localparam logic CAUSE_OVF    = 1'b1;

    localparam logic [3:0] IORD_VEC_DEFAULT  = 4'd2;  // address mux -> vector base 252
    localparam logic [3:0] PCSRC_VEC_DEFAULT = 4'd3;  // PC mux -> zero-extended vector byte
    localparam logic [3:0] SRCA_PC_DEFAULT   = 4'd0;  // ALU A -> PC
    localparam logic [3:0] SRCB_FOUR_DEFAULT = 4'd1;  // ALU B -> constant 4

endpackage

// File: rtl/exception_sequencer_if.sv
// exception_sequencer_if
// Datapath control bundle driven by the exception sequencer while it owns the
// datapath. master = sequencer (drives), slave = control-unit forwarding mux.
//   alu_src_a/alu_src_b/alu_op : ALU operand selects and operation
//   epc_write/cause_write      : EPC and Cause register loads
//   int_cause                  : Cause mux select (0 opcode, 1 overflow)
//   iord/mem_wr                : memory address select, memory write (always 0)
//   treat_src                  : vector byte select within MemData
//   pc_source/pc_write         : PC mux select and PC load
// There is no handshake: the bundle is a set of level selects qualified by the
// sequencer's busy output, which the control unit uses to pick this bundle.
interface exception_sequencer_if;
    logic [3:0] alu_src_a;
    logic [3:0] alu_src_b;
    logic [2:0] alu_op;
    logic       epc_write;
    logic       cause_write;
    logic [3:0] int_cause;
    logic [3:0] iord;
    logic       mem_wr;
    logic       treat_src;
    logic [3:0] pc_source;
    logic       pc_write;

    modport master (
        output alu_src_a, alu_src_b, alu_op, epc_write, cause_write,
               int_cause, iord, mem_wr, treat_src, pc_source, pc_write
    );

    modport slave (
        input  alu_src_a, alu_src_b, alu_op, epc_write, cause_write,
               int_cause, iord, mem_wr, treat_src, pc_source, pc_write
    );
endinterface

// File: rtl/exc_wait_counter.sv
// exc_wait_counter
// 4-bit load/decrement counter used to time the memory read of the vector.
//   clock, reset : rising-edge clock, asynchronous active-low reset
//   load         : load load_val (has priority over dec)
//   load_val     : value to load
//   dec          : decrement by one
//   zero         : count is zero
module exc_wait_counter (
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec,
    output logic       zero
);
    logic [3:0] count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= 4'd0;
        end else if (load) begin
            count <= load_val;
        end else if (dec) begin
            count <= count - 4'd1;
        end
    end

    assign zero = (count == 4'd0);
endmodule

// File: rtl/exception_sequencer.sv
// exception_sequencer
// Multicycle sequencer that takes over the datapath on an exception: saves
// PC-4 into EPC and the cause into Cause, reads the handler byte from the
// vector region and loads it into PC.
//   clock, reset       : rising-edge clock, asynchronous active-low reset
//   opcode_exc/ovf_exc : exception requests, sampled only in IDLE
//   busy               : sequencer owns the datapath (selects ctrl bundle)
//   done               : one-cycle pulse, PC holds the handler address
//   double_fault       : sticky, a request arrived while busy
//   state_out          : current FSM state for debug
//   ctrl               : datapath control bundle (master side)
module exception_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int         MEM_WAIT  = 2,
    parameter logic [3:0] IORD_VEC  = IORD_VEC_DEFAULT,
    parameter logic [3:0] PCSRC_VEC = PCSRC_VEC_DEFAULT,
    parameter logic [3:0] SRCA_PC   = SRCA_PC_DEFAULT,
    parameter logic [3:0] SRCB_FOUR = SRCB_FOUR_DEFAULT
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   opcode_exc,
    input  logic                   ovf_exc,
    output logic                   busy,
    output logic                   done,
    output logic                   double_fault,
    output logic [2:0]             state_out,
    exception_sequencer_if.master  ctrl
);
    exc_state_t state, state_nxt;
    logic       cause_q;
    logic       req;
    logic       cnt_load;
    logic       cnt_dec;
    logic       cnt_zero;

    assign req = opcode_exc | ovf_exc;

    exc_wait_counter u_wait (
        .clock    (clock),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (4'(MEM_WAIT - 1)),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= EXC_IDLE;
            cause_q      <= CAUSE_OPCODE;
            double_fault <= 1'b0;
        end else begin
            state <= state_nxt;
            // Overflow wins when both requests arrive together.
            if (state == EXC_IDLE && req) begin
                cause_q <= ovf_exc ? CAUSE_OVF : CAUSE_OPCODE;
            end
            // Requests during an active sequence are dropped, not queued.
            if ((state == EXC_SAVE || state == EXC_FETCH || state == EXC_LOAD) && req) begin
                double_fault <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt         = state;
        busy              = 1'b0;
        done              = 1'b0;
        cnt_load          = 1'b0;
        cnt_dec           = 1'b0;
        ctrl.alu_src_a    = 4'd0;
        ctrl.alu_src_b    = 4'd0;
        ctrl.alu_op       = ALU_LOAD;
        ctrl.epc_write    = 1'b0;
        ctrl.cause_write  = 1'b0;
        ctrl.int_cause    = 4'd0;
        ctrl.iord         = 4'd0;
        ctrl.mem_wr       = 1'b0;
        ctrl.treat_src    = 1'b0;
        ctrl.pc_source    = 4'd0;
        ctrl.pc_write     = 1'b0;

        unique case (state)
            EXC_IDLE: begin
                if (req) state_nxt = EXC_SAVE;
            end
            EXC_SAVE: begin
                // EPC <= PC - 4 through the ALU; ALU overflow here is ignored.
                busy             = 1'b1;
                ctrl.alu_src_a   = SRCA_PC;
                ctrl.alu_src_b   = SRCB_FOUR;
                ctrl.alu_op      = ALU_SUB;
                ctrl.epc_write   = 1'b1;
                ctrl.cause_write = 1'b1;
                ctrl.int_cause   = {3'b000, cause_q};
                cnt_load         = 1'b1;
                state_nxt        = EXC_FETCH;
            end
            EXC_FETCH: begin
                // Counter was loaded with MEM_WAIT-1, so FETCH lasts MEM_WAIT cycles.
                busy      = 1'b1;
                ctrl.iord = IORD_VEC;
                if (cnt_zero) begin
                    state_nxt = EXC_LOAD;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            EXC_LOAD: begin
                // Overflow vector sits in the low byte, opcode vector in the high byte.
                busy           = 1'b1;
                ctrl.iord      = IORD_VEC;
                ctrl.treat_src = cause_q;
                ctrl.pc_source = PCSRC_VEC;
                ctrl.pc_write  = 1'b1;
                state_nxt      = EXC_DONE;
            end
            EXC_DONE: begin
                done      = 1'b1;
                state_nxt = EXC_IDLE;
            end
            default: begin
                state_nxt = EXC_IDLE;
            end
        endcase
    end

    assign state_out = state;
endmodule

// File: tb/tb_exception_sequencer.sv
module tb_exception_sequencer;
  localparam int W = 33;

  logic clock;
  logic reset;
  logic opc0, ovf0, opc1, ovf1, opc2, ovf2;
  logic busy0, done0, df0, busy1, done1, df1, busy2, done2, df2;
  logic [2:0] st0, st1, st2;
  logic [W-1:0] obs0, obs1, obs2;

  logic [W-1:0] exp_q[$];
  int n_assert;
  int n_fail;

  exception_sequencer_if if0();
  exception_sequencer_if if1();
  exception_sequencer_if if2();

  exception_sequencer #(.MEM_WAIT(2)) dut0 (
    .clock(clock), .reset(reset), .opcode_exc(opc0), .ovf_exc(ovf0),
    .busy(busy0), .done(done0), .double_fault(df0), .state_out(st0), .ctrl(if0)
  );
  exception_sequencer #(.MEM_WAIT(1)) dut1 (
    .clock(clock), .reset(reset), .opcode_exc(opc1), .ovf_exc(ovf1),
    .busy(busy1), .done(done1), .double_fault(df1), .state_out(st1), .ctrl(if1)
  );
  exception_sequencer #(.MEM_WAIT(15)) dut2 (
    .clock(clock), .reset(reset), .opcode_exc(opc2), .ovf_exc(ovf2),
    .busy(busy2), .done(done2), .double_fault(df2), .state_out(st2), .ctrl(if2)
  );

  assign obs0 = {busy0, done0, st0, if0.alu_src_a, if0.alu_src_b, if0.alu_op, if0.epc_write,
                 if0.cause_write, if0.int_cause, if0.iord, if0.mem_wr, if0.treat_src,
                 if0.pc_source, if0.pc_write};
  assign obs1 = {busy1, done1, st1, if1.alu_src_a, if1.alu_src_b, if1.alu_op, if1.epc_write,
                 if1.cause_write, if1.int_cause, if1.iord, if1.mem_wr, if1.treat_src,
                 if1.pc_source, if1.pc_write};
  assign obs2 = {busy2, done2, st2, if2.alu_src_a, if2.alu_src_b, if2.alu_op, if2.epc_write,
                 if2.cause_write, if2.int_cause, if2.iord, if2.mem_wr, if2.treat_src,
                 if2.pc_source, if2.pc_write};

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [W-1:0] mk(
      input logic b, input logic d, input logic [2:0] st, input logic [3:0] sa,
      input logic [3:0] sb, input logic [2:0] op, input logic ew, input logic cw,
      input logic [3:0] ic, input logic [3:0] io, input logic ts, input logic [3:0] ps,
      input logic pw);
    return {b, d, st, sa, sb, op, ew, cw, ic, io, 1'b0, ts, ps, pw};
  endfunction

  function automatic logic [W-1:0] idle_vec();
    return '0;
  endfunction

  // expected per-cycle outputs of a full sequence, starting in the SAVE cycle
  task automatic push_seq(input logic cause, input int mw);
    exp_q.push_back(mk(1'b1, 1'b0, 3'd1, 4'd0, 4'd1, 3'd2, 1'b1, 1'b1, {3'b000, cause},
                       4'd0, 1'b0, 4'd0, 1'b0));
    for (int i = 0; i < mw; i++)
      exp_q.push_back(mk(1'b1, 1'b0, 3'd2, 4'd0, 4'd0, 3'd0, 1'b0, 1'b0, 4'd0,
                         4'd2, 1'b0, 4'd0, 1'b0));
    exp_q.push_back(mk(1'b1, 1'b0, 3'd3, 4'd0, 4'd0, 3'd0, 1'b0, 1'b0, 4'd0,
                       4'd2, cause, 4'd3, 1'b1));
    exp_q.push_back(mk(1'b0, 1'b1, 3'd4, 4'd0, 4'd0, 3'd0, 1'b0, 1'b0, 4'd0,
                       4'd0, 1'b0, 4'd0, 1'b0));
    exp_q.push_back(idle_vec());
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(idle_vec());
  endtask

  // scoreboard: pop one expected vector per cycle and compare at the negedge
  task automatic check_n(input int sel, input int n, input string tag);
    logic [W-1:0] exp_v;
    logic [W-1:0] got;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      exp_v = exp_q.pop_front();
      case (sel)
        0: got = obs0;
        1: got = obs1;
        default: got = obs2;
      endcase
      n_assert++;
      assert (got === exp_v) else begin
        n_fail++;
        $error("FAIL %s cyc%0d got=%h exp=%h", tag, i, got, exp_v);
      end
    end
  endtask

  // driver: request is held across exactly one rising edge; call in the low phase
  task automatic fire(input int sel, input logic opc, input logic ovf);
    case (sel)
      0: begin opc0 = opc; ovf0 = ovf; end
      1: begin opc1 = opc; ovf1 = ovf; end
      default: begin opc2 = opc; ovf2 = ovf; end
    endcase
    @(posedge clock);
    #1;
    opc0 = 1'b0; ovf0 = 1'b0; opc1 = 1'b0; ovf1 = 1'b0; opc2 = 1'b0; ovf2 = 1'b0;
  endtask

  task automatic check_bit(input string tag, input logic got, input logic exp_b);
    n_assert++;
    assert (got === exp_b) else begin
      n_fail++;
      $error("FAIL %s got=%b exp=%b", tag, got, exp_b);
    end
  endtask

  // cycles from the request edge until done is seen (cycle 1 = first after the edge)
  task automatic measure(input int sel, input int mw, input string tag);
    int n;
    logic d;
    fire(sel, 1'b1, 1'b0);
    n = 1;
    while (n < 40) begin
      @(negedge clock);
      d = (sel == 1) ? done1 : done2;
      if (d) break;
      n++;
    end
    n_assert++;
    assert (n == 3 + mw) else begin
      n_fail++;
      $error("FAIL %s latency got=%0d exp=%0d", tag, n, 3 + mw);
    end
    @(negedge clock);
  endtask

  initial begin
    n_assert = 0;
    n_fail = 0;
    reset = 1'b0;
    opc0 = 1'b0; ovf0 = 1'b0; opc1 = 1'b0; ovf1 = 1'b0; opc2 = 1'b0; ovf2 = 1'b0;

    // reset held 3 cycles
    repeat (3) @(posedge clock);
    @(negedge clock);
    n_assert++;
    assert (obs0 === '0) else begin
      n_fail++;
      $error("FAIL reset_outputs got=%h exp=%h", obs0, {W{1'b0}});
    end
    check_bit("reset_df", df0, 1'b0);
    reset = 1'b1;
    push_idle(2);
    check_n(0, 2, "idle_after_reset");
    check_bit("idle_df", df0, 1'b0);

    // opcode exception, MEM_WAIT=2
    fire(0, 1'b1, 1'b0);
    push_seq(1'b0, 2);
    check_n(0, 6, "opcode_seq");

    // simultaneous requests: overflow wins
    fire(0, 1'b1, 1'b1);
    push_seq(1'b1, 2);
    check_n(0, 6, "both_seq");

    // overflow only
    fire(0, 1'b0, 1'b1);
    push_seq(1'b1, 2);
    check_n(0, 6, "ovf_seq");

    // double fault: overflow pulse during FETCH of an opcode sequence
    fire(0, 1'b1, 1'b0);
    push_seq(1'b0, 2);
    check_n(0, 2, "df_seq_a");
    check_bit("df_before", df0, 1'b0);
    fire(0, 1'b0, 1'b1);
    @(negedge clock);
    check_bit("df_set", df0, 1'b1);
    exp_q.pop_front();  // second FETCH cycle, sampled above for df only
    check_n(0, 3, "df_seq_b");
    push_idle(4);
    check_n(0, 4, "df_no_second_seq");
    check_bit("df_sticky", df0, 1'b1);

    // reset during FETCH aborts at once
    fire(0, 1'b1, 1'b0);
    push_seq(1'b0, 2);
    check_n(0, 2, "rst_seq");
    exp_q.delete();
    #2 reset = 1'b0;
    #1;
    n_assert++;
    assert (obs0 === '0) else begin
      n_fail++;
      $error("FAIL async_reset got=%h exp=%h", obs0, {W{1'b0}});
    end
    check_bit("async_reset_df", df0, 1'b0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    push_idle(6);
    check_n(0, 6, "after_abort_idle");

    // MEM_WAIT=1 full sequence and latency
    fire(1, 1'b0, 1'b1);
    push_seq(1'b1, 1);
    check_n(1, 5, "mw1_seq");
    measure(1, 1, "mw1");

    // MEM_WAIT=15 latency and full sequence
    measure(2, 15, "mw15");
    fire(2, 1'b1, 1'b0);
    push_seq(1'b0, 15);
    check_n(2, 19, "mw15_seq");
    check_bit("mw15_df", df2, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
